dict_builder: RTL
=================

Name: dict_builder

Overview:
- Dictionary header writer: the write-side counterpart of the word finder.
- Parses the next blank-delimited name from the TIB and writes a new dictionary header at HERE over the shared 8-bit memory block: link field (2 bytes, little-endian), length byte, then name bytes.
- On success it returns the new context (latest word address) and the new HERE.
- Headers it produces are byte-compatible with the finder walk: LFA low, LFA high, len, name; link 'hffff terminates the chain.

Parameters:
DSZ, 8, data path width (bytes).
ASZ, 17, memory address width.
MAXLEN, 31, longest legal name length in bytes.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
mb_if  mb8_io master  -  memory block port; drives ai, we, vi
en  input  1  start request; sampled only in IDL
here  input  ASZ  next free dictionary byte address
ctx  input  16  current latest-word address (link to store)
tib  input  ASZ  TIB cursor where parsing starts
vw  input  DSZ  memory read data; valid the cycle after ai presented
bsy  output  1  1 while building a header
err  output  1  1 if the last build failed (empty or too-long name, or here[16]=1)
tib_o  output  ASZ  TIB address of the delimiter that ended the name
here_o  output  ASZ  new HERE after a successful build
ctx_o  output  16  new context = address of the new header

Behaviour:
- Reset (async, rst_n=0): bsy=0, err=0, tib_o=0, here_o=0, ctx_o='hffff. State=IDL; we=0 immediately. Reset mid-build aborts with no further writes; bytes already written stay in memory.
- Memory: one access per cycle. we=1 only in WR, LEN, LK0, LK1; vi is driven from a register. Read data appears on vw one cycle after ai.
- Internal registers: base (latched here), link (latched ctx), a1 (TIB pointer), n (name count, 6 bits), ch (latched char).
- IDL: on en=1, latch here/ctx/tib, set n=0, bsy<=1, err<=0, go to RD.
  - If here[16]=1, set err=1 and go to DON.
  - en=1 while bsy=1 is ignored.
- RD: ai=a1, read. Go to CHK.
- CHK: examine vw.
  - Space (8'h20) with n=0: a1++, go to RD (skip leading blanks).
  - Space or NUL with n>0: tib_o<=a1, go to LEN.
  - NUL with n=0: err<=1, tib_o<=a1, go to DON.
  - Any other char with n=MAXLEN: err<=1, tib_o<=a1, go to DON.
  - Any other char otherwise: ch<=vw, go to WR.
- WR: ai=base+3+n, vi=ch, we=1; n++, a1++, go to RD.
- LEN: ai=base+2, vi=n. Go to LK0.
- LK0: ai=base, vi=link[7:0]. Go to LK1.
- LK1: ai=base+1, vi=link[15:8]. Go to DON.
- DON: bsy<=0, go to IDL.
  - If err=0: ctx_o<=base[15:0], here_o<=base+3+n.
  - If err=1: ctx_o and here_o hold their previous values.
- Latency: bsy high for 2S+3N+6 cycles (S = leading spaces, N = name chars). A too-long name still writes MAXLEN chars into scratch space past HERE; they are not committed.
- Arithmetic: addresses are ASZ-bit; base+3+n never wraps because here[16]=0 is enforced. Link stored as 16 bits.

Test Plan:
- TIB@0x100="  dup\0", here=0x0200, ctx=0xFFFF, pulse en -> writes [0x203]='d', [0x204]='u', [0x205]='p', [0x202]=3, [0x200]=FF, [0x201]=FF; bsy high 19 cycles; ctx_o=0x0200, here_o=0x0206, tib_o=0x105, err=0.
- Chain: then TIB@0x110="drop ", here=0x0206, ctx=0x0200 -> [0x206]=00, [0x207]=02, [0x208]=4, "drop" at 0x209..0x20C; ctx_o=0x0206, here_o=0x020D, tib_o=0x114. A finder run for "dup" on the result must hit.
- TIB="   \0" -> err=1, no we pulses, ctx_o/here_o unchanged, tib_o=tib+3, bsy high 2*3+2+1 cycles.
- 32-char name with MAXLEN=31 -> err=1, exactly 31 WR writes, no LEN/LK writes, ctx_o/here_o unchanged, tib_o at the 32nd char.
- rst_n low during WR of char 2 -> we drops that cycle, bsy=0, ctx_o=0xFFFF; a fresh en afterwards builds normally.
- en held high through a build -> exactly one header built per IDL entry; a second build starts the cycle after DON.

Source files
------------

// File: rtl/dict_builder_if.sv
// Byte-wide memory block port shared by the dictionary walker and writer.
// The builder drives the address, write strobe and write data.
interface mb8_io #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
);
    logic [ASZ-1:0] ai;
    logic           we;
    logic [DSZ-1:0] vi;

    modport master (output ai, output we, output vi);
    modport slave  (input ai, input we, input vi);
endinterface

// File: rtl/dict_builder.sv
// Dictionary header writer: parses the next blank-delimited TIB name and
// lays down link/len/name at HERE in the finder's byte format.
module dict_builder #(
    parameter int DSZ    = 8,
    parameter int ASZ    = 17,
    parameter int MAXLEN = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    mb8_io.master           mb_if,
    input  logic            en,
    input  logic [ASZ-1:0]  here,
    input  logic [15:0]     ctx,
    input  logic [ASZ-1:0]  tib,
    input  logic [DSZ-1:0]  vw,
    output logic            bsy,
    output logic            err,
    output logic [ASZ-1:0]  tib_o,
    output logic [ASZ-1:0]  here_o,
    output logic [15:0]     ctx_o
);
    typedef enum logic [2:0] {
        IDL, RD, CHK, WR, LEN, LK0, LK1, DON
    } state_t;

    state_t         r_st;
    state_t         w_nxt;
    logic [ASZ-1:0] r_base;
    logic [ASZ-1:0] r_a1;
    logic [ASZ-1:0] r_tib_o;
    logic [ASZ-1:0] r_here_o;
    logic [15:0]    r_link;
    logic [15:0]    r_ctx_o;
    logic [5:0]     r_n;
    logic [DSZ-1:0] r_ch;
    logic           r_bsy;
    logic           r_err;

    logic           w_sp;
    logic           w_nul;
    logic           w_nz;
    logic           w_full;
    logic [ASZ-1:0] w_end;
    logic [ASZ-1:0] w_ai;
    logic           w_we;
    logic [DSZ-1:0] w_vi;

    assign w_sp   = (vw == DSZ'(8'h20));
    assign w_nul  = (vw == '0);
    assign w_nz   = (r_n != '0);
    assign w_full = (r_n == 6'(MAXLEN));
    // First free byte after the name; also the committed HERE.
    assign w_end  = r_base + ASZ'(r_n) + ASZ'(3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= IDL;
        else        r_st <= w_nxt;
    end

    always_comb begin
        w_nxt = r_st;
        w_ai  = r_a1;
        w_we  = 1'b0;
        w_vi  = r_ch;
        unique case (r_st)
            IDL: if (en) w_nxt = here[ASZ-1] ? DON : RD;
            RD:  w_nxt = CHK;
            CHK: begin
                unique case (1'b1)
                    w_sp && !w_nz:          w_nxt = RD;
                    (w_sp || w_nul) && w_nz: w_nxt = LEN;
                    w_nul && !w_nz:         w_nxt = DON;
                    default:                w_nxt = w_full ? DON : WR;
                endcase
            end
            WR: begin
                w_ai  = w_end;
                w_vi  = r_ch;
                w_we  = 1'b1;
                w_nxt = RD;
            end
            LEN: begin
                w_ai  = r_base + ASZ'(2);
                w_vi  = DSZ'(r_n);
                w_we  = 1'b1;
                w_nxt = LK0;
            end
            LK0: begin
                w_ai  = r_base;
                w_vi  = DSZ'(r_link[7:0]);
                w_we  = 1'b1;
                w_nxt = LK1;
            end
            LK1: begin
                w_ai  = r_base + ASZ'(1);
                w_vi  = DSZ'(r_link[15:8]);
                w_we  = 1'b1;
                w_nxt = DON;
            end
            DON:     w_nxt = IDL;
            default: w_nxt = IDL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_a1     <= '0;
            r_link   <= '0;
            r_n      <= '0;
            r_ch     <= '0;
            r_bsy    <= 1'b0;
            r_err    <= 1'b0;
            r_tib_o  <= '0;
            r_here_o <= '0;
            r_ctx_o  <= 16'hffff;
        end else begin
            unique case (r_st)
                IDL: begin
                    if (en) begin
                        r_base <= here;
                        r_link <= ctx;
                        r_a1   <= tib;
                        r_n    <= '0;
                        r_bsy  <= 1'b1;
                        r_err  <= here[ASZ-1];
                    end
                end
                CHK: begin
                    if (w_nxt == RD)                   r_a1    <= r_a1 + ASZ'(1);
                    if (w_nxt == LEN || w_nxt == DON)  r_tib_o <= r_a1;
                    if (w_nxt == DON)                  r_err   <= 1'b1;
                    if (w_nxt == WR)                   r_ch    <= vw;
                end
                WR: begin
                    r_n  <= r_n + 6'd1;
                    r_a1 <= r_a1 + ASZ'(1);
                end
                DON: begin
                    r_bsy <= 1'b0;
                    if (!r_err) begin
                        r_ctx_o  <= r_base[15:0];
                        r_here_o <= w_end;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mb_if.ai = w_ai;
    assign mb_if.we = w_we;
    assign mb_if.vi = w_vi;
    assign bsy      = r_bsy;
    assign err      = r_err;
    assign tib_o    = r_tib_o;
    assign here_o   = r_here_o;
    assign ctx_o    = r_ctx_o;
endmodule
